// File: rtl/calc_entry_seq.sv
// Operand-entry sequencer for a two's-complement add/sub stage: collects operand1, operator and
// operand2 on debounced Enter presses, captures the adder result and flags signed overflow.
// Optional build macro CALC_CHAIN_EN: Enter in S_DONE chains the result into operand1 and resumes at S_OP.
module calc_entry_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             op_sw,
  input  logic             enter_btn,
  input  logic             clear_btn,
  input  logic [WIDTH-1:0] add_result,
  output logic [WIDTH-1:0] operand1,
  output logic [WIDTH-1:0] operand2,
  output logic             operation,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] operand1_q, operand1_d;
  logic [WIDTH-1:0] operand2_q, operand2_d;
  logic             operation_q, operation_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  // Two-flop synchronizers plus a "previous" flop so a held button yields a single pulse.
  logic enter_s1_q, enter_s2_q, enter_prev_q;
  logic clear_s1_q, clear_s2_q, clear_prev_q;
  logic enter_pulse, clear_pulse;
  logic msb_a, msb_b, msb_r, ovf_calc;

  assign enter_pulse = enter_s2_q & ~enter_prev_q;
  assign clear_pulse = clear_s2_q & ~clear_prev_q;

  assign msb_a    = operand1_q[WIDTH-1];
  assign msb_b    = operand2_q[WIDTH-1];
  assign msb_r    = add_result[WIDTH-1];
  assign ovf_calc = operation_q ? ((msb_a != msb_b) && (msb_r != msb_a))
                                : ((msb_a == msb_b) && (msb_r != msb_a));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_s1_q   <= 1'b0;
      enter_s2_q   <= 1'b0;
      enter_prev_q <= 1'b0;
      clear_s1_q   <= 1'b0;
      clear_s2_q   <= 1'b0;
      clear_prev_q <= 1'b0;
    end else begin
      enter_s1_q   <= enter_btn;
      enter_s2_q   <= enter_s1_q;
      enter_prev_q <= enter_s2_q;
      clear_s1_q   <= clear_btn;
      clear_s2_q   <= clear_s1_q;
      clear_prev_q <= clear_s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_A;
      operand1_q  <= '0;
      operand2_q  <= '0;
      operation_q <= 1'b0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand1_q  <= operand1_d;
      operand2_q  <= operand2_d;
      operation_q <= operation_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    operand1_d  = operand1_q;
    operand2_d  = operand2_q;
    operation_d = operation_q;
    result_d    = result_q;
    valid_d     = valid_q;
    ovf_d       = ovf_q;
    // Clear overrides everything, including a same-cycle Enter and the S_EXEC capture.
    if (clear_pulse) begin
      state_d = S_A;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (enter_pulse) begin
            operand1_d = sw;
            state_d    = S_OP;
          end
        end
        S_OP: begin
          if (enter_pulse) begin
            operation_d = op_sw;
            state_d     = S_B;
          end
        end
        S_B: begin
          if (enter_pulse) begin
            operand2_d = sw;
            state_d    = S_EXEC;
          end
        end
        S_EXEC: begin
          result_d = add_result;
          valid_d  = 1'b1;
          ovf_d    = ovf_calc;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (enter_pulse) begin
            valid_d = 1'b0;
            ovf_d   = 1'b0;
`ifdef CALC_CHAIN_EN
            operand1_d = result_q;
            state_d    = S_OP;
`else
            state_d    = S_A;
`endif
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  assign operand1     = operand1_q;
  assign operand2     = operand2_q;
  assign operation    = operation_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign overflow     = ovf_q;
  assign state        = state_q;

endmodule

// File: tb/tb_calc_entry_seq.sv
// Directed bench for calc_entry_seq with a behavioural add/sub stage; honours CALC_CHAIN_EN.
module tb_calc_entry_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       op_sw;
  logic       enter_btn;
  logic       clear_btn;
  logic [3:0] add_result;
  logic [3:0] operand1;
  logic [3:0] operand2;
  logic       operation;
  logic [3:0] result;
  logic       result_valid;
  logic       overflow;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Downstream adder model: wraps modulo 16.
  assign add_result = operation ? (operand1 - operand2) : (operand1 + operand2);

  calc_entry_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .op_sw(op_sw),
    .enter_btn(enter_btn), .clear_btn(clear_btn), .add_result(add_result),
    .operand1(operand1), .operand2(operand2), .operation(operation),
    .result(result), .result_valid(result_valid), .overflow(overflow), .state(state)
  );

  // Raise the chosen buttons, hold until just past the acting edge, then release.
  task automatic press(input logic en, input logic cl);
    repeat (2) @(negedge clk);
    enter_btn = en;
    clear_btn = cl;
    repeat (3) @(posedge clk);
    @(negedge clk);
    enter_btn = 1'b0;
    clear_btn = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw = 4'd0; op_sw = 1'b0; enter_btn = 1'b0; clear_btn = 1'b0;
    #3;
    checks++;
    if (state !== 3'd0 || operand1 !== 4'd0 || operand2 !== 4'd0 || operation !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs state=%0d op1=%0d op2=%0d opn=%0d want all 0", state, operand1, operand2, operation);
    end
    checks++;
    if (result !== 4'd0 || result_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_result result=%0d valid=%0d ovf=%0d want all 0", result, result_valid, overflow);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL reset_idle state got %0d want 0", state);
    end
  endtask

  task automatic do_calc(input logic [3:0] a, input logic op, input logic [3:0] b,
                         input logic [3:0] exp_res, input logic exp_ovf);
    sw = a;
    press(1'b1, 1'b0);
    op_sw = op;
    press(1'b1, 1'b0);
    sw = b;
    press(1'b1, 1'b0);
    checks++;
    if (state !== 3'd3 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL calc_exec %0d/%0d/%0d state=%0d valid=%0d want 3/0", a, op, b, state, result_valid);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL calc_done %0d/%0d/%0d state=%0d valid=%0d want 4/1", a, op, b, state, result_valid);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("FAIL calc_result %0d/%0d/%0d got %b want %b", a, op, b, result, exp_res);
    end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL calc_ovf %0d/%0d/%0d got %0d want %0d", a, op, b, overflow, exp_ovf);
    end
    checks++;
    if (operand1 !== a || operand2 !== b || operation !== op) begin
      errors++;
      $display("FAIL calc_operands got %0d/%0d/%0d want %0d/%0d/%0d", operand1, operation, operand2, a, op, b);
    end
  endtask

  task automatic finish_done(input logic [3:0] exp_res);
    sw = 4'($urandom_range(0, 15));
    press(1'b1, 1'b0);
`ifdef CALC_CHAIN_EN
    checks++;
    if (state !== 3'd1 || operand1 !== exp_res || result_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL chain_enter state=%0d op1=%0d valid=%0d ovf=%0d want 1/%0d/0/0", state, operand1, result_valid, overflow, exp_res);
    end
    press(1'b0, 1'b1);
`endif
    checks++;
    if (state !== 3'd0 || result_valid !== 1'b0 || overflow !== 1'b0 || result !== exp_res) begin
      errors++;
      $display("FAIL done_exit state=%0d valid=%0d ovf=%0d result=%0d want 0/0/0/%0d", state, result_valid, overflow, result, exp_res);
    end
  endtask

  task automatic test_plain_add();
    do_calc(4'd3, 1'b0, 4'd2, 4'd5, 1'b0);
    finish_done(4'd5);
  endtask

  task automatic test_overflow();
    do_calc(4'd7, 1'b0, 4'd1, 4'b1000, 1'b1);
    finish_done(4'b1000);
    do_calc(4'b1000, 1'b1, 4'd1, 4'b0111, 1'b1);
    finish_done(4'b0111);
    do_calc(4'b1101, 1'b1, 4'd2, 4'b1011, 1'b0);
    finish_done(4'b1011);
    do_calc(4'd7, 1'b1, 4'b1111, 4'b1000, 1'b1);
    finish_done(4'b1000);
    do_calc(4'd3, 1'b0, 4'b1011, 4'b1110, 1'b0);
    finish_done(4'b1110);
  endtask

  task automatic test_hold();
    sw = 4'd6;
    repeat (2) @(negedge clk);
    enter_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 3) sw = 4'(i);
    end
    checks++;
    if (state !== 3'd1 || operand1 !== 4'd6) begin
      errors++;
      $display("FAIL hold_single state=%0d op1=%0d want 1/6", state, operand1);
    end
    enter_btn = 1'b0;
    press(1'b0, 1'b1);
    checks++;
    if (state !== 3'd0 || operand1 !== 4'd6) begin
      errors++;
      $display("FAIL hold_clear state=%0d op1=%0d want 0/6", state, operand1);
    end
  endtask

  task automatic test_clear();
    sw = 4'd5;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL clear_setup state got %0d want 2", state);
    end
    press(1'b0, 1'b1);
    checks++;
    if (state !== 3'd0 || operand1 !== 4'd5 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL clear_in_b state=%0d op1=%0d valid=%0d want 0/5/0", state, operand1, result_valid);
    end
    sw = 4'd9;
    press(1'b1, 1'b1);
    checks++;
    if (state !== 3'd0 || operand1 !== 4'd5) begin
      errors++;
      $display("FAIL clear_collision state=%0d op1=%0d want 0/5", state, operand1);
    end
    do_calc(4'd4, 1'b0, 4'd1, 4'd5, 1'b0);
    press(1'b0, 1'b1);
    checks++;
    if (state !== 3'd0 || result_valid !== 1'b0 || result !== 4'd5 || operand2 !== 4'd1) begin
      errors++;
      $display("FAIL clear_in_done state=%0d valid=%0d result=%0d op2=%0d want 0/0/5/1", state, result_valid, result, operand2);
    end
  endtask

  task automatic test_reset_mid();
    sw = 4'd1;
    press(1'b1, 1'b0);
    op_sw = 1'b1;
    press(1'b1, 1'b0);
    sw = 4'd2;
    press(1'b1, 1'b0);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_setup state got %0d want 3", state);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || operand1 !== 4'd0 || operand2 !== 4'd0 || operation !== 1'b0 ||
        result !== 4'd0 || result_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async state=%0d op1=%0d op2=%0d opn=%0d res=%0d valid=%0d ovf=%0d want all 0",
               state, operand1, operand2, operation, result, result_valid, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 3'd0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after state=%0d valid=%0d want 0/0", state, result_valid);
    end
  endtask

`ifdef CALC_CHAIN_EN
  task automatic test_chain();
    do_calc(4'd3, 1'b0, 4'd2, 4'd5, 1'b0);
    press(1'b1, 1'b0);
    checks++;
    if (state !== 3'd1 || operand1 !== 4'd5) begin
      errors++;
      $display("FAIL chain_load state=%0d op1=%0d want 1/5", state, operand1);
    end
    op_sw = 1'b1;
    press(1'b1, 1'b0);
    sw = 4'd6;
    press(1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (state !== 3'd4 || result !== 4'b1111 || overflow !== 1'b0 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL chain_sub state=%0d result=%b ovf=%0d valid=%0d want 4/1111/0/1", state, result, overflow, result_valid);
    end
    press(1'b0, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_plain_add();
    test_overflow();
    test_hold();
    test_clear();
    test_reset_mid();
`ifdef CALC_CHAIN_EN
    test_chain();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_entry_seq.md
Name: calc_entry_seq

Overview:
- Operand-entry sequencer that sits directly upstream of the 4-bit two's-complement add/sub stage.
- Collects operand1, operator and operand2 from board switches, one debounced Enter press per step, and drives the adder's operand and operation inputs.
- Captures the adder's combinational result, flags signed overflow, and holds the result for the display stage.

Parameters:
- WIDTH, 4, operand/result width in bits (two's complement).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- sw  input  WIDTH  operand value from switches.
- op_sw  input  1  operator select: 0 = add, 1 = subtract.
- enter_btn  input  1  raw Enter button, asynchronous, level.
- clear_btn  input  1  raw Clear button, asynchronous, level.
- add_result  input  WIDTH  combinational result returned from the add/sub stage.
- operand1  output  WIDTH  to adder, registered.
- operand2  output  WIDTH  to adder, registered.
- operation  output  1  to adder, registered (0 = add, 1 = sub).
- result  output  WIDTH  captured result, registered.
- result_valid  output  1  high while result holds a fresh computation.
- overflow  output  1  signed overflow of the captured result.
- state  output  3  current FSM state, for status LEDs.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - all outputs to 0;
  - state to S_A;
  - both synchronizer chains to 0.
- Button conditioning:
  - enter_btn and clear_btn each pass through a 2-flop synchronizer plus a "previous" flop.
  - Pulse = sync2 & ~prev.
  - A press acts on the 3rd rising clk edge after the button goes high.
  - A held button gives exactly one pulse; no new pulse until the button is released and pressed again.
- State encoding: S_A = 0, S_OP = 1, S_B = 2, S_EXEC = 3, S_DONE = 4. Codes 5–7 are illegal and return to S_A on the next edge.
- S_A: on enter pulse, operand1 <= sw; go to S_OP.
- S_OP: on enter pulse, operation <= op_sw; go to S_B.
- S_B: on enter pulse, operand2 <= sw; go to S_EXEC.
- S_EXEC: unconditional, exactly one cycle, so the adder settles on the registered operands. On leaving:
  - result <= add_result;
  - result_valid <= 1;
  - overflow computed as below;
  - go to S_DONE.
- Overflow rule, with a = operand1 MSB, b = operand2 MSB, r = add_result MSB:
  - add: (a == b) and (r != a);
  - sub: (a != b) and (r != a).
- Result wrap: no saturation; result is the adder's value modulo 2^WIDTH. Examples: 7 + 1 gives 4'b1000; -8 - 1 gives 4'b0111.
- S_DONE: result, overflow and result_valid are held.
  - On enter pulse, default build: result_valid <= 0, overflow <= 0, go to S_A.
  - result itself keeps its last value until the next S_EXEC capture.
- Latency: 1 cycle from entering S_EXEC until result_valid goes high.
- Clear pulse, any state:
  - go to S_A;
  - result_valid <= 0, overflow <= 0;
  - operand and result registers are kept.
- Clear and enter pulses on the same cycle: clear wins and the enter is discarded.
- Inputs sw and op_sw are only sampled on the enter-pulse edge of their own state. Changing them at any other time has no effect.
- Reset asserted mid-sequence: immediate return to the reset values; partial entry is lost.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: in S_DONE, an enter pulse loads operand1 <= result, clears result_valid and overflow, and goes to S_OP. This chains the previous result as the next left operand. Clear still returns to S_A.
- Undefined: S_DONE + enter goes to S_A as described in Behaviour.

Test Plan:
- Plain add: reset; enter sw = 3, op_sw = 0, sw = 2 with one press each → operand1 = 3, operand2 = 2, operation = 0; result = 5 with result_valid = 1 exactly 1 cycle after S_EXEC; overflow = 0; state = 4.
- Overflow: 7 + 1 → result = 4'b1000, overflow = 1. Then -8 (4'b1000) - 1 → result = 4'b0111, overflow = 1. -3 - 2 → result = 4'b1011, overflow = 0.
- Debounce/hold: hold enter_btn high for 20 cycles in S_A → single transition to S_OP, operand1 latched once. Toggle sw while the button stays held → operand1 unchanged.
- Clear and collision: clear in S_B after operand1 = 5 → state = 0, operand1 still 5, result_valid = 0. Raise clear and enter together → state = 0, enter ignored.
- Reset mid-operation: drop rst_n during S_EXEC → all outputs 0 and state = 0 immediately, with no clock needed.
- CALC_CHAIN_EN: 3 + 2 = 5, then enter in S_DONE → state = 1, operand1 = 5; select sub and enter sw = 6 → result = 4'b1111 (-1), overflow = 0. Without the macro, the same enter → state = 0.
